// File: rtl/partida_pkg.sv
// Shared definitions for the game-round controller: state encoding,
// the debug code for unencoded states and the round-counter ceiling.
package partida_pkg;

    typedef enum logic [4:0] {
        INICIAL       = 5'd0,
        RESETA_TUDO   = 5'd1,
        PREPARA_JOGO  = 5'd2,
        ARMAZENA_JOGO = 5'd3,
        PREPARA_NOITE = 5'd4,
        VEZ_NOITE     = 5'd5,
        PROXIMO_NOITE = 5'd6,
        PREPARA_DIA   = 5'd7,
        VOTACAO       = 5'd8,
        PROXIMO_VOTO  = 5'd9,
        APURA         = 5'd10,
        FIM_JOGO      = 5'd11
    } estado_t;

    // Reported on db_estado when the state register holds an unused code
    localparam logic [4:0] ESTADO_ERRO = 5'b11111;

    // Night counter stops here instead of wrapping
    localparam logic [3:0] RODADA_MAX = 4'd15;

    // True in the two states where a player's turn is running
    function automatic logic em_turno(input estado_t e);
        return (e == VEZ_NOITE) || (e == VOTACAO);
    endfunction

    // True for every code that names a real state
    function automatic logic estado_valido(input estado_t e);
        return e <= FIM_JOGO;
    endfunction

endpackage

// File: rtl/contador_m.sv
// Modulus-M counter with synchronous clear and enable; fim flags the last
// count so the caller can detect the end of a sequence without a compare.
module contador_m #(
    parameter int M = 8,
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         fim
);

    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] count_reg;

    // Count up while enabled, wrapping to zero after the last value
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= (count_reg == ULTIMO) ? '0 : count_reg + 1'b1;
        end
    end

    assign count = count_reg;
    assign fim   = (count_reg == ULTIMO);

endmodule

// File: rtl/unidade_controle_partida.sv
// Control unit for one match: setup, night turns, day voting and tally.
// Turn length is bounded by a timer; a registered flag remembers whether
// each turn ended by the player passing or by the timer running out.
module unidade_controle_partida
    import partida_pkg::*;
#(
    parameter int N_JOGADORES = 8,
    parameter int T_LIMITE    = 1000,
    localparam int W_JOG      = (N_JOGADORES > 2) ? $clog2(N_JOGADORES) : 1,
    localparam int W_T        = $clog2(T_LIMITE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             jogar,
    input  logic             passa,
    input  logic             fim_jogo,
    output logic             rst_global,
    output logic             zera_CS,
    output logic             e_seed_reg,
    output logic             noite,
    output logic             e_voto,
    output logic             e_apura,
    output logic             timeout,
    output logic [W_JOG-1:0] jogador_atual,
    output logic [3:0]       rodada,
    output logic [4:0]       db_estado
);

    estado_t        estado_reg;
    estado_t        estado_next;
    logic [W_T-1:0] timer_count;
    logic           timer_fim;
    logic           jog_fim;
    logic           passou_reg;
    logic [3:0]     rodada_reg;

    // Turn timer: runs only while a turn is in progress. Clearing on the
    // next state keeps it at zero in every other state, including the
    // PROXIMO_* state right after a turn.
    contador_m #(
        .M (T_LIMITE),
        .W (W_T)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (!em_turno(estado_next)),
        .enable (em_turno(estado_reg)),
        .count  (timer_count),
        .fim    (timer_fim)
    );

    // Player index: advances once per PROXIMO_* visit. After the last
    // player it wraps to 0, so day setup and tally already see player 0.
    contador_m #(
        .M (N_JOGADORES),
        .W (W_JOG)
    ) u_jogador (
        .clock  (clock),
        .reset  (reset),
        .clear  ((estado_reg == PREPARA_NOITE) || (estado_reg == PREPARA_DIA)
                 || (estado_reg == RESETA_TUDO)),
        .enable ((estado_reg == PROXIMO_NOITE) || (estado_reg == PROXIMO_VOTO)),
        .count  (jogador_atual),
        .fim    (jog_fim)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_reg <= INICIAL;
        end else begin
            estado_reg <= estado_next;
        end
    end

    // Next-state logic; passa wins over timer expiry simply because either
    // one exits the turn and the flag below records which it was.
    always_comb begin
        estado_next = estado_reg;
        case (estado_reg)
            INICIAL:       if (jogar) estado_next = RESETA_TUDO;
            RESETA_TUDO:   estado_next = PREPARA_JOGO;
            PREPARA_JOGO:  if (passa) estado_next = ARMAZENA_JOGO;
            ARMAZENA_JOGO: estado_next = PREPARA_NOITE;
            PREPARA_NOITE: estado_next = VEZ_NOITE;
            VEZ_NOITE:     if (passa || timer_fim) estado_next = PROXIMO_NOITE;
            PROXIMO_NOITE: estado_next = jog_fim ? PREPARA_DIA : VEZ_NOITE;
            PREPARA_DIA:   estado_next = VOTACAO;
            VOTACAO:       if (passa || timer_fim) estado_next = PROXIMO_VOTO;
            PROXIMO_VOTO:  estado_next = jog_fim ? APURA : VOTACAO;
            APURA:         estado_next = fim_jogo ? FIM_JOGO : PREPARA_NOITE;
            FIM_JOGO:      if (jogar) estado_next = RESETA_TUDO;
            default:       estado_next = INICIAL;
        endcase
    end

    // Pass flag: sampled every turn cycle, so on the exit cycle it holds
    // whether the exit was a pass (1) or a timer expiry (0)
    always_ff @(posedge clock) begin
        if (reset) begin
            passou_reg <= 1'b0;
        end else if (em_turno(estado_reg)) begin
            passou_reg <= passa;
        end
    end

    // Night counter: one step per tally that does not end the match,
    // saturating; a new match starts again from zero
    always_ff @(posedge clock) begin
        if (reset || (estado_reg == RESETA_TUDO)) begin
            rodada_reg <= 4'd0;
        end else if ((estado_reg == APURA) && !fim_jogo && (rodada_reg != RODADA_MAX)) begin
            rodada_reg <= rodada_reg + 4'd1;
        end
    end

    assign rodada = rodada_reg;

    // Moore output decodes of the current state
    always_comb begin
        rst_global = (estado_reg == INICIAL) || (estado_reg == RESETA_TUDO);
        zera_CS    = rst_global;
        e_seed_reg = (estado_reg == ARMAZENA_JOGO);
        noite      = (estado_reg == PREPARA_NOITE) || (estado_reg == VEZ_NOITE)
                     || (estado_reg == PROXIMO_NOITE);
        e_apura    = (estado_reg == APURA);
        e_voto     = (estado_reg == PROXIMO_VOTO) && passou_reg;
        timeout    = ((estado_reg == PROXIMO_NOITE) || (estado_reg == PROXIMO_VOTO))
                     && !passou_reg;
        db_estado  = estado_valido(estado_reg) ? 5'(estado_reg) : ESTADO_ERRO;
    end

endmodule

// File: tb/tb_unidade_controle_partida.sv
// Directed bench for the match controller with 4 players and a 10-cycle turn.
module tb_unidade_controle_partida;

    logic       clock;
    logic       reset;
    logic       jogar;
    logic       passa;
    logic       fim_jogo;
    logic       rst_global;
    logic       zera_CS;
    logic       e_seed_reg;
    logic       noite;
    logic       e_voto;
    logic       e_apura;
    logic       timeout;
    logic [1:0] jogador_atual;
    logic [3:0] rodada;
    logic [4:0] db_estado;

    int n_checks;
    int n_fail;

    unidade_controle_partida #(
        .N_JOGADORES (4),
        .T_LIMITE    (10)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .jogar         (jogar),
        .passa         (passa),
        .fim_jogo      (fim_jogo),
        .rst_global    (rst_global),
        .zera_CS       (zera_CS),
        .e_seed_reg    (e_seed_reg),
        .noite         (noite),
        .e_voto        (e_voto),
        .e_apura       (e_apura),
        .timeout       (timeout),
        .jogador_atual (jogador_atual),
        .rodada        (rodada),
        .db_estado     (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // One turn ended by passa on its first cycle, then step past PROXIMO_*
    task automatic passar;
        passa = 1'b1;
        tick;
        passa = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        n_checks++;
        if (db_estado !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_db_estado: got %0d expected 0", db_estado);
        end
        n_checks++;
        if ({rst_global, zera_CS} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_rst: got rst_global=%b zera_CS=%b expected 1 1", rst_global, zera_CS);
        end
        n_checks++;
        if ({e_seed_reg, noite, e_voto, e_apura, timeout} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {e_seed_reg, noite, e_voto, e_apura, timeout});
        end
        n_checks++;
        if (jogador_atual !== 2'd0 || rodada !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got jogador=%0d rodada=%0d expected 0 0", jogador_atual, rodada);
        end
        $display("test_reset: db_estado=%0d rst_global=%b", db_estado, rst_global);
    endtask

    task automatic test_start;
        int seed_cycles;
        logic [4:0] esperado [0:5];
        logic [4:0] visto [0:5];
        seed_cycles = 0;
        visto[0] = db_estado;
        jogar = 1'b1;
        tick;
        jogar = 1'b0;
        visto[1] = db_estado;
        seed_cycles += int'(e_seed_reg);
        tick;
        visto[2] = db_estado;
        seed_cycles += int'(e_seed_reg);
        passa = 1'b1;
        tick;
        passa = 1'b0;
        visto[3] = db_estado;
        seed_cycles += int'(e_seed_reg);
        tick;
        visto[4] = db_estado;
        seed_cycles += int'(e_seed_reg);
        tick;
        visto[5] = db_estado;
        seed_cycles += int'(e_seed_reg);
        esperado = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (visto[i] !== esperado[i]) begin
                n_fail++;
                $display("FAIL start_db_estado[%0d]: got %0d expected %0d", i, visto[i], esperado[i]);
            end
        end
        n_checks++;
        if (seed_cycles != 1) begin
            n_fail++;
            $display("FAIL start_e_seed_cycles: got %0d expected 1", seed_cycles);
        end
        $display("test_start: db sequence checked, e_seed_reg high for %0d cycle(s)", seed_cycles);
    endtask

    task automatic test_night;
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if (db_estado !== 5'd5 || jogador_atual !== 2'(p) || noite !== 1'b1) begin
                n_fail++;
                $display("FAIL night_turn[%0d]: got db=%0d jogador=%0d noite=%b expected 5 %0d 1",
                         p, db_estado, jogador_atual, noite, p);
            end
            tick;
            passa = 1'b1;
            tick;
            passa = 1'b0;
            n_checks++;
            if (db_estado !== 5'd6 || noite !== 1'b1 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL night_next[%0d]: got db=%0d noite=%b timeout=%b expected 6 1 0",
                         p, db_estado, noite, timeout);
            end
            tick;
        end
        n_checks++;
        if (db_estado !== 5'd7 || jogador_atual !== 2'd0 || noite !== 1'b0) begin
            n_fail++;
            $display("FAIL night_to_day: got db=%0d jogador=%0d noite=%b expected 7 0 0",
                     db_estado, jogador_atual, noite);
        end
        tick;
        n_checks++;
        if (db_estado !== 5'd8 || jogador_atual !== 2'd0) begin
            n_fail++;
            $display("FAIL vote_entry: got db=%0d jogador=%0d expected 8 0", db_estado, jogador_atual);
        end
        $display("test_night: 4 night turns, now db_estado=%0d", db_estado);
    endtask

    task automatic test_vote_timeout;
        int ciclos;
        passa = 1'b1;
        tick;
        passa = 1'b0;
        n_checks++;
        if (db_estado !== 5'd9 || e_voto !== 1'b1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL vote_pass_p0: got db=%0d e_voto=%b timeout=%b expected 9 1 0",
                     db_estado, e_voto, timeout);
        end
        tick;
        passar;
        n_checks++;
        if (db_estado !== 5'd8 || jogador_atual !== 2'd2) begin
            n_fail++;
            $display("FAIL vote_p2_entry: got db=%0d jogador=%0d expected 8 2", db_estado, jogador_atual);
        end
        ciclos = 1;
        while (db_estado == 5'd8 && ciclos < 30) begin
            tick;
            if (db_estado == 5'd8) ciclos++;
        end
        n_checks++;
        if (ciclos != 10) begin
            n_fail++;
            $display("FAIL vote_timeout_length: got %0d cycles expected 10", ciclos);
        end
        n_checks++;
        if (db_estado !== 5'd9 || timeout !== 1'b1 || e_voto !== 1'b0) begin
            n_fail++;
            $display("FAIL vote_timeout_flags: got db=%0d timeout=%b e_voto=%b expected 9 1 0",
                     db_estado, timeout, e_voto);
        end
        tick;
        $display("test_vote_timeout: player 2 spent %0d cycles in VOTACAO", ciclos);
    endtask

    task automatic test_pass_at_limit;
        n_checks++;
        if (db_estado !== 5'd8 || jogador_atual !== 2'd3) begin
            n_fail++;
            $display("FAIL limit_entry: got db=%0d jogador=%0d expected 8 3", db_estado, jogador_atual);
        end
        repeat (9) tick;
        n_checks++;
        if (db_estado !== 5'd8) begin
            n_fail++;
            $display("FAIL limit_still_voting: got db=%0d expected 8", db_estado);
        end
        passa = 1'b1;
        tick;
        passa = 1'b0;
        n_checks++;
        if (db_estado !== 5'd9 || e_voto !== 1'b1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_pass_priority: got db=%0d e_voto=%b timeout=%b expected 9 1 0",
                     db_estado, e_voto, timeout);
        end
        tick;
        n_checks++;
        if (db_estado !== 5'd10 || e_apura !== 1'b1 || rodada !== 4'd0) begin
            n_fail++;
            $display("FAIL limit_apura: got db=%0d e_apura=%b rodada=%0d expected 10 1 0",
                     db_estado, e_apura, rodada);
        end
        $display("test_pass_at_limit: passa at timer 9 gave e_voto=%b timeout=%b", e_voto, timeout);
    endtask

    task automatic test_rodada_saturation;
        int esperado;
        for (int k = 1; k <= 16; k++) begin
            fim_jogo = 1'b0;
            tick;
            esperado = (k > 15) ? 15 : k;
            n_checks++;
            if (db_estado !== 5'd4 || rodada !== 4'(esperado)) begin
                n_fail++;
                $display("FAIL rodada_step[%0d]: got db=%0d rodada=%0d expected 4 %0d",
                         k, db_estado, rodada, esperado);
            end
            tick;
            repeat (4) passar;
            tick;
            repeat (4) passar;
        end
        n_checks++;
        if (db_estado !== 5'd10 || rodada !== 4'd15) begin
            n_fail++;
            $display("FAIL rodada_saturated: got db=%0d rodada=%0d expected 10 15", db_estado, rodada);
        end
        fim_jogo = 1'b1;
        tick;
        fim_jogo = 1'b0;
        n_checks++;
        if (db_estado !== 5'd11) begin
            n_fail++;
            $display("FAIL fim_jogo_entry: got db=%0d expected 11", db_estado);
        end
        passa = 1'b1;
        tick;
        passa = 1'b0;
        tick;
        n_checks++;
        if (db_estado !== 5'd11) begin
            n_fail++;
            $display("FAIL fim_jogo_hold: got db=%0d expected 11", db_estado);
        end
        jogar = 1'b1;
        tick;
        jogar = 1'b0;
        n_checks++;
        if (db_estado !== 5'd1 || rst_global !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: got db=%0d rst_global=%b expected 1 1", db_estado, rst_global);
        end
        $display("test_rodada_saturation: rodada reached 15, restart db_estado=%0d", db_estado);
    endtask

    task automatic test_reset_mid_turn;
        tick;
        passa = 1'b1;
        tick;
        passa = 1'b0;
        tick;
        tick;
        passar;
        passar;
        repeat (5) tick;
        n_checks++;
        if (db_estado !== 5'd5 || jogador_atual !== 2'd2) begin
            n_fail++;
            $display("FAIL midturn_setup: got db=%0d jogador=%0d expected 5 2", db_estado, jogador_atual);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        n_checks++;
        if (db_estado !== 5'd0 || jogador_atual !== 2'd0 || rst_global !== 1'b1 || noite !== 1'b0) begin
            n_fail++;
            $display("FAIL midturn_reset: got db=%0d jogador=%0d rst_global=%b noite=%b expected 0 0 1 0",
                     db_estado, jogador_atual, rst_global, noite);
        end
        $display("test_reset_mid_turn: after reset db_estado=%0d jogador=%0d", db_estado, jogador_atual);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        jogar    = 1'b0;
        passa    = 1'b0;
        fim_jogo = 1'b0;
        #2;
        test_reset;
        test_start;
        test_night;
        test_vote_timeout;
        test_pass_at_limit;
        test_rodada_saturation;
        test_reset_mid_turn;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
